// File: rtl/edge_gen.sv
// Pulse generator: each request on `in` yields a width-cycle pulse followed by
// a gap-cycle rest. Requests that arrive while busy are queued in a saturating backlog.
module edge_gen #(
   parameter bit active      = 1'b1,
   parameter int width       = 1,
   parameter int gap         = 1,
   parameter int max_pending = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   output logic       out,
   output logic       busy,
   output logic [7:0] pending,
   output logic       drop
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACT  = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam logic [7:0] W_LAST = 8'(width - 1);
   localparam logic [7:0] G_LAST = 8'(gap - 1);
   localparam logic [7:0] P_MAX  = 8'(max_pending);

   logic [1:0] state, nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] pend_nxt;
   logic       drop_nxt;
   logic       start, from_backlog, queue_in;

   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      start   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = 8'd0;
            if (in || pending != 8'd0) begin
               nxt   = ACT;
               start = 1'b1;
            end
         end
         ACT: begin
            if (cnt == W_LAST) begin
               nxt     = GAP;
               cnt_nxt = 8'd0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         GAP: begin
            if (cnt == G_LAST) begin
               cnt_nxt = 8'd0;
               if (in || pending != 8'd0) begin
                  nxt   = ACT;
                  start = 1'b1;
               end else begin
                  nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: begin
            nxt     = IDLE;
            cnt_nxt = 8'd0;
         end
      endcase
   end

   // The backlog has priority over a fresh request; a fresh request that is not
   // started directly joins the backlog.
   always_comb begin
      from_backlog = start && (pending != 8'd0);
      queue_in     = in && !(start && !from_backlog);
      pend_nxt     = pending;
      drop_nxt     = 1'b0;
      if (from_backlog && !queue_in)
         pend_nxt = pending - 8'd1;
      else if (queue_in && !from_backlog) begin
         if (pending == P_MAX)
            drop_nxt = 1'b1;
         else
            pend_nxt = pending + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         out     <= ~active;
         pending <= 8'd0;
         drop    <= 1'b0;
      end else begin
         state   <= nxt;
         cnt     <= cnt_nxt;
         out     <= (nxt == ACT) ? active : ~active;
         pending <= pend_nxt;
         drop    <= drop_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_edge_gen.sv
// Randomized scoreboard bench for edge_gen: a phase/backlog model predicts each
// cycle's outputs; a monitor pops and compares after every rising edge.
module tb_edge_gen;

   localparam int W = 3;
   localparam int G = 2;
   localparam int M = 2;
   localparam int P = W + G;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in  = 1'b0;
   logic       out1, busy1, drop1, out0, busy0, drop0;
   logic [7:0] pend1, pend0;

   edge_gen #(.active(1'b1), .width(W), .gap(G), .max_pending(M)) dut1 (
      .clk(clk), .rst(rst), .in(in), .out(out1), .busy(busy1), .pending(pend1), .drop(drop1));
   edge_gen #(.active(1'b0), .width(W), .gap(G), .max_pending(M)) dut0 (
      .clk(clk), .rst(rst), .in(in), .out(out0), .busy(busy0), .pending(pend0), .drop(drop0));

   always #5 clk = ~clk;

   typedef struct {
      logic       pulse;
      logic       busy;
      logic [7:0] pending;
      logic       drop;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Model: phase = cycles since current pulse began (-1 when idle), backlog count.
   int phase = -1;
   int backlog = 0;
   bit mdrop = 0;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
      end
   endtask

   // Apply one cycle of stimulus and push the outputs expected after the edge.
   task automatic cycle(input bit i, input bit r);
      bit   can_start, starting, use_bl, in_q;
      int   nb;
      exp_t e;
      @(negedge clk);
      in  = i;
      rst = r;
      if (r) begin
         phase = -1; backlog = 0; mdrop = 0;
      end else begin
         can_start = (phase < 0) || (phase == P - 1);
         starting  = can_start && (i || backlog > 0);
         use_bl    = starting && backlog > 0;
         in_q      = i && !(starting && !use_bl);
         nb        = backlog - int'(use_bl) + int'(in_q);
         mdrop     = (nb > M);
         backlog   = (nb > M) ? M : nb;
         if (starting)           phase = 0;
         else if (phase < 0)     phase = -1;
         else if (phase == P-1)  phase = -1;
         else                    phase = phase + 1;
      end
      e.pulse   = (phase >= 0) && (phase < W);
      e.busy    = (phase >= 0);
      e.pending = 8'(backlog);
      e.drop    = mdrop;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("out_act1",  {7'd0, out1},  {7'd0, e.pulse});
            check("out_act0",  {7'd0, out0},  {7'd0, ~e.pulse});
            check("busy",      {7'd0, busy1}, {7'd0, e.busy});
            check("busy_act0", {7'd0, busy0}, {7'd0, e.busy});
            check("pending",   pend1,         e.pending);
            check("pend_act0", pend0,         e.pending);
            check("drop",      {7'd0, drop1}, {7'd0, e.drop});
            check("drop_act0", {7'd0, drop0}, {7'd0, e.drop});
         end
      end
   end

   initial begin : stim
      cycle(1'b0, 1'b1); cycle(1'b0, 1'b1);
      idle(5);
      // single request
      cycle(1'b1, 1'b0); idle(8);
      // three back-to-back requests fill the backlog
      repeat (3) cycle(1'b1, 1'b0);
      idle(16);
      // four requests: the last one overflows and is dropped
      repeat (4) cycle(1'b1, 1'b0);
      idle(16);
      // second request lands on the final gap cycle
      cycle(1'b1, 1'b0); idle(4); cycle(1'b1, 1'b0); idle(8);
      // reset mid-pulse with in high
      cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b1); idle(10);
      // request on the first cycle after reset
      cycle(1'b0, 1'b1); cycle(1'b1, 1'b0); idle(8);
      // randomized traffic with varying density and rare resets
      for (int blk = 0; blk < 20; blk++) begin
         int dens;
         dens = $urandom_range(1, 4);
         for (int k = 0; k < 80; k++)
            cycle(($urandom_range(0, dens) == 0), ($urandom_range(0, 149) == 0));
      end
      idle(4);
      @(negedge clk); @(negedge clk);
      check("queue_drained", 8'(q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
